cevero_vreg_sequencer: RTL

//  Downstream of the DVFS controller: consumes its requested voltage level and steps the external

---
 rtl/cevero_dvfs_pkg.sv | 41 ++++
 rtl/cevero_dvfs_timer.sv | 40 ++++
 rtl/cevero_vreg_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/cevero_dvfs_pkg.sv
// +--------------------------------------------------------------------------+
// | cevero_dvfs_pkg: shared types and helpers for the DVFS voltage sequencer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package cevero_dvfs_pkg;

  typedef logic [2:0] level_t;

  localparam level_t MAX_LEVEL = 3'd5;

  typedef enum logic [1:0] {
    DIV_1 = 2'd0,
    DIV_2 = 2'd1,
    DIV_4 = 2'd2
  } div_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FDOWN  = 3'd1,
    ST_VREQ   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_FUP    = 3'd4,
    ST_FAULT  = 3'd5
  } seq_state_e;

  function automatic level_t clamp_level(input level_t lvl);
    return (lvl > MAX_LEVEL) ? MAX_LEVEL : lvl;
  endfunction

  // Lower voltage levels only sustain slower clocks.
  function automatic div_e level2div(input level_t lvl);
    if (lvl <= 3'd1)      return DIV_4;
    else if (lvl <= 3'd3) return DIV_2;
    else                  return DIV_1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cevero_dvfs_timer.sv
// +--------------------------------------------------------------------------+
// | cevero_dvfs_timer: saturating up-counter, done when LIMIT is reached     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module cevero_dvfs_timer #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  typedef logic [W-1:0] cnt_t;
  localparam cnt_t FULL = cnt_t'(LIMIT);
  localparam cnt_t LAST = cnt_t'(LIMIT - 1);

  cnt_t cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != FULL)) begin
      cnt_q <= cnt_q + cnt_t'(1);
    end
  end

  // Flags the enabled cycle in which the count reaches LIMIT, so the owner
  // spends exactly LIMIT enabled cycles before acting on it.
  assign done_o = (cnt_q == FULL) || (en_i && (cnt_q == LAST));

endmodule

`default_nettype wire

// File: rtl/cevero_vreg_sequencer.sv
// +--------------------------------------------------------------------------+
// | cevero_vreg_sequencer: steps the regulator one level at a time, keeping  |
// | the clock divider safe for the applied voltage. Revision: 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module cevero_vreg_sequencer
  import cevero_dvfs_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned ACK_TIMEOUT   = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] target_level_i,
  input  logic [2:0] def_level_i,
  output logic       vreg_req_o,
  output logic [2:0] vreg_level_o,
  input  logic       vreg_ack_i,
  output logic [1:0] clk_div_o,
  output logic [2:0] cur_level_o,
  output logic       busy_o,
  output logic       err_timeout_o
);

  seq_state_e state;
  level_t     nxt;
  logic       dir_up;
  logic       ack_expired;
  logic       settle_done;
  level_t     target;
  level_t     def_level;

  assign target    = clamp_level(target_level_i);
  assign def_level = clamp_level(def_level_i);

  cevero_dvfs_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state != ST_VREQ),
    .en_i   (state == ST_VREQ),
    .done_o (ack_expired)
  );

  cevero_dvfs_timer #(.LIMIT(SETTLE_CYCLES)) u_settle_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state == ST_VREQ),
    .en_i   (state == ST_SETTLE),
    .done_o (settle_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= ST_IDLE;
      cur_level_o  <= def_level;
      vreg_level_o <= def_level;
      nxt          <= def_level;
      clk_div_o    <= level2div(def_level);
      vreg_req_o   <= 1'b0;
      dir_up       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (target > cur_level_o) begin
            dir_up       <= 1'b1;
            nxt          <= cur_level_o + 3'd1;
            vreg_level_o <= cur_level_o + 3'd1;
            vreg_req_o   <= 1'b1;
            state        <= ST_VREQ;
          end else if (target < cur_level_o) begin
            dir_up <= 1'b0;
            nxt    <= cur_level_o - 3'd1;
            state  <= ST_FDOWN;
          end
        end
        // Slow the clock before the voltage is allowed to drop.
        ST_FDOWN: begin
          clk_div_o    <= level2div(nxt);
          vreg_level_o <= nxt;
          vreg_req_o   <= 1'b1;
          state        <= ST_VREQ;
        end
        ST_VREQ: begin
          if (vreg_ack_i) begin
            vreg_req_o <= 1'b0;
            state      <= ST_SETTLE;
          end else if (ack_expired) begin
            vreg_req_o <= 1'b0;
            state      <= ST_FAULT;
          end
        end
        ST_SETTLE: begin
          if (settle_done) begin
            cur_level_o <= nxt;
            state       <= dir_up ? ST_FUP : ST_IDLE;
          end
        end
        ST_FUP: begin
          clk_div_o <= level2div(cur_level_o);
          state     <= ST_IDLE;
        end
        ST_FAULT: state <= ST_FAULT;
        default:  state <= ST_FAULT;
      endcase
    end
  end

  assign busy_o        = (state != ST_IDLE) && (state != ST_FAULT);
  assign err_timeout_o = (state == ST_FAULT);

endmodule

`default_nettype wire
